// File: rtl/sistema_pio_pkg.sv
// Shared constants for the sistema input PIO: register addresses, edge-capture modes
// and a width helper for the optional debounce counters.
package sistema_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sistema_pio_debounce.sv
// Single-bit debouncer: a new level is accepted only after it has been held
// for DEBOUNCE_CYCLES consecutive clocks.
module sistema_pio_debounce
    import sistema_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_bit,
    output logic deb_bit
);

    localparam int CW_RAW = clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] count_reg;
    logic          candidate_reg;
    logic          stable_reg;

    // Any disagreement with the candidate restarts the stability count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= '0;
            candidate_reg <= 1'b0;
            stable_reg    <= 1'b0;
        end else if (sync_bit != candidate_reg) begin
            candidate_reg <= sync_bit;
            count_reg     <= '0;
        end else if (count_reg == COUNT_MAX) begin
            stable_reg    <= candidate_reg;
        end else begin
            count_reg     <= count_reg + 1'b1;
        end
    end

    assign deb_bit = stable_reg;

endmodule

// File: rtl/sistema_pio_in_irq.sv
// WIDTH-bit Avalon-MM input PIO with synchroniser, per-bit edge capture and masked irq.
// Optional per-bit debouncing is compiled in with SISTEMA_PIO_DEBOUNCE_EN.
module sistema_pio_in_irq
    import sistema_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask_reg, irqmask_next;
    logic [WIDTH-1:0] edgecap_reg, edgecap_next;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      readdata_reg, readdata_next;
    logic             irq_reg, irq_next;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

`ifdef SISTEMA_PIO_DEBOUNCE_EN
    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
        sistema_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .sync_bit (sync_q[gi]),
            .deb_bit  (in_q[gi])
        );
    end
`else
    assign in_q = sync_q;
`endif

    genvar ei;
    for (ei = 0; ei < WIDTH; ei++) begin : g_edge
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_vec[ei] = ~in_q[ei] & prev_reg[ei];
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_vec[ei] = in_q[ei] ^ prev_reg[ei];
        end else begin : g_rise
            assign edge_vec[ei] = in_q[ei] & ~prev_reg[ei];
        end
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // A new edge overrides a simultaneous write-1-to-clear of the same bit
    always_comb begin
        irqmask_next = irqmask_reg;
        clear_mask   = '0;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_next = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clear_mask = writedata[WIDTH-1:0];
        end
        edgecap_next = (edgecap_reg & ~clear_mask) | edge_vec;
        irq_next     = |(edgecap_next & irqmask_next);

        readdata_next = '0;
        case (address)
            ADDR_DATA:    readdata_next[WIDTH-1:0] = in_q;
            ADDR_IRQMASK: readdata_next[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: readdata_next[WIDTH-1:0] = edgecap_reg;
            default:      readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg     <= '0;
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            prev_reg     <= in_q;
            irqmask_reg  <= irqmask_next;
            edgecap_reg  <= edgecap_next;
            readdata_reg <= readdata_next;
            irq_reg      <= irq_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule
